// File: rtl/pc8k_video_pkg.sv
// Shared constants and types for the pc8k text-mode video path.
package pc8k_video_pkg;

   localparam int H_ACTIVE   = 640;
   localparam int TXT_COLS   = 80;
   localparam int TXT_ROWS   = 25;
   localparam int CELL_W     = 8;
   localparam int CELL_H     = 16;
   localparam int PIPE_LAT   = 4;
   localparam int BLINK_BITS = 5;
   localparam int V_ACTIVE   = TXT_ROWS * CELL_H;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

   // row*80 + col as shift-and-add
   function automatic logic [10:0] cell_addr(input logic [4:0] row,
                                             input logic [6:0] col);
      return {row, 6'b0} + 11'({row, 4'b0}) + 11'(col);
   endfunction

endpackage

// File: rtl/crt_delay_line.sv
// Fixed-depth register pipe with synchronous reset to a chosen value.
module crt_delay_line #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] pipe_q [DEPTH];
   logic [WIDTH-1:0] pipe_d [DEPTH];

   always_comb begin
      pipe_d[0] = d;
      for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= RST_VAL;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/crt_text_gen.sv
// 80x25 text-mode pixel generator, 4-clock counter-to-pixel pipeline.
// Optional blinking block cursor: define CRT_TEXT_CURSOR_EN.
module crt_text_gen
   import pc8k_video_pkg::*;
#(
   parameter int         V_TOP      = 40,
   parameter logic [2:0] FG_DEFAULT = 3'b111
) (
   input  logic        I_CLK,
   input  logic        I_RST,
   input  logic [9:0]  I_H_CNT,
   input  logic [9:0]  I_V_CNT,
   input  logic        I_HS,
   input  logic        I_VS,
   input  logic [2:0]  I_FG,
   output logic [10:0] O_VRAM_ADDR,
   input  logic [7:0]  I_VRAM_DATA,
   output logic [10:0] O_CG_ADDR,
   input  logic [7:0]  I_CG_DATA,
   input  logic [6:0]  I_CUR_X,
   input  logic [4:0]  I_CUR_Y,
   input  logic        I_CUR_ON,
   output logic        O_R,
   output logic        O_G,
   output logic        O_B,
   output logic        O_DE,
   output logic        O_HS,
   output logic        O_VS
);

   logic [9:0]  vy;
   logic        in_area;
   logic [6:0]  col;
   logic [4:0]  row;
   logic [2:0]  line;
   logic        cur_hit;
   logic        blink_vis;
   logic        vs_fall;

   logic [2:0]  line_s1;
   logic        de_s2;
   logic        cur_s2;
   logic [2:0]  hbit_s2;
   sync_t       sync_s0;
   sync_t       sync_s4;

   logic [10:0] vram_addr_q, vram_addr_d;
   logic [10:0] cg_addr_q, cg_addr_d;
   logic        pix_q, pix_d;
   logic [2:0]  rgb_q, rgb_d;
   logic [2:0]  fg_q, fg_d;
   logic        vs_prev_q, vs_prev_d;

   // Above V_TOP the subtraction wraps high, so one compare bounds both ends.
   assign vy      = I_V_CNT - 10'(V_TOP);
   assign in_area = (I_H_CNT < 10'(H_ACTIVE)) && (vy < 10'(V_ACTIVE));
   assign col     = I_H_CNT[9:3];
   assign row     = vy[8:4];
   assign line    = vy[3:1];
   assign vs_fall = vs_prev_q & ~I_VS;
   assign sync_s0 = '{hs: I_HS, vs: I_VS, de: in_area};

`ifdef CRT_TEXT_CURSOR_EN
   logic [BLINK_BITS-1:0] blink_q, blink_d;

   always_comb begin
      blink_d = blink_q;
      if (vs_fall) blink_d = blink_q + BLINK_BITS'(1);
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) blink_q <= '0;
      else       blink_q <= blink_d;
   end

   assign blink_vis = ~blink_q[BLINK_BITS-1];
   assign cur_hit   = I_CUR_ON & in_area
                    & (col == I_CUR_X) & (row == I_CUR_Y);
`else
   logic unused_cursor;
   assign unused_cursor = ^{I_CUR_X, I_CUR_Y, I_CUR_ON};
   assign blink_vis     = 1'b0;
   assign cur_hit       = 1'b0;
`endif

   crt_delay_line #(
      .WIDTH   (3),
      .DEPTH   (1),
      .RST_VAL (3'b000)
   ) u_line_dl (
      .clk (I_CLK),
      .rst (I_RST),
      .d   (line),
      .q   (line_s1)
   );

   crt_delay_line #(
      .WIDTH   (5),
      .DEPTH   (2),
      .RST_VAL (5'b00000)
   ) u_bit_dl (
      .clk (I_CLK),
      .rst (I_RST),
      .d   ({in_area, cur_hit, I_H_CNT[2:0]}),
      .q   ({de_s2, cur_s2, hbit_s2})
   );

   crt_delay_line #(
      .WIDTH   ($bits(sync_t)),
      .DEPTH   (PIPE_LAT),
      .RST_VAL (SYNC_IDLE)
   ) u_sync_dl (
      .clk (I_CLK),
      .rst (I_RST),
      .d   (sync_s0),
      .q   (sync_s4)
   );

   always_comb begin
      vram_addr_d = '0;
      if (in_area) vram_addr_d = cell_addr(row, col);
      cg_addr_d = {I_VRAM_DATA, line_s1};
      pix_d     = de_s2 & (I_CG_DATA[3'd7 - hbit_s2]
                           ^ (cur_s2 & blink_vis));
      rgb_d     = pix_q ? fg_q : 3'b000;
      fg_d      = vs_fall ? I_FG : fg_q;
      vs_prev_d = I_VS;
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         vram_addr_q <= '0;
         cg_addr_q   <= '0;
         pix_q       <= 1'b0;
         rgb_q       <= 3'b000;
         fg_q        <= FG_DEFAULT;
         vs_prev_q   <= 1'b1;
      end else begin
         vram_addr_q <= vram_addr_d;
         cg_addr_q   <= cg_addr_d;
         pix_q       <= pix_d;
         rgb_q       <= rgb_d;
         fg_q        <= fg_d;
         vs_prev_q   <= vs_prev_d;
      end
   end

   assign O_VRAM_ADDR = vram_addr_q;
   assign O_CG_ADDR   = cg_addr_q;
   assign {O_R, O_G, O_B} = rgb_q;
   assign O_DE = sync_s4.de;
   assign O_HS = sync_s4.hs;
   assign O_VS = sync_s4.vs;

endmodule

// File: tb/tb_crt_text_gen.sv
// Directed vector bench for crt_text_gen with behavioural VRAM and font ROM.
module tb_crt_text_gen;

`ifdef CRT_TEXT_CURSOR_EN
   localparam bit CUR_BUILT = 1'b1;
`else
   localparam bit CUR_BUILT = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [9:0]  h_cnt, v_cnt;
   logic        hs_i, vs_i;
   logic [2:0]  fg_i;
   logic [10:0] vram_addr, cg_addr;
   logic [7:0]  vram_data, cg_data;
   logic [6:0]  cur_x;
   logic [4:0]  cur_y;
   logic        cur_on;
   logic        r_o, g_o, b_o, de_o, hs_o, vs_o;

   logic [7:0]  vram [2048];
   logic [7:0]  font [2048];

   int n_vec = 0;
   int n_err = 0;

   assign vram_data = vram[vram_addr];
   assign cg_data   = font[cg_addr];

   crt_text_gen dut (
      .I_CLK       (clk),
      .I_RST       (rst),
      .I_H_CNT     (h_cnt),
      .I_V_CNT     (v_cnt),
      .I_HS        (hs_i),
      .I_VS        (vs_i),
      .I_FG        (fg_i),
      .O_VRAM_ADDR (vram_addr),
      .I_VRAM_DATA (vram_data),
      .O_CG_ADDR   (cg_addr),
      .I_CG_DATA   (cg_data),
      .I_CUR_X     (cur_x),
      .I_CUR_Y     (cur_y),
      .I_CUR_ON    (cur_on),
      .O_R         (r_o),
      .O_G         (g_o),
      .O_B         (b_o),
      .O_DE        (de_o),
      .O_HS        (hs_o),
      .O_VS        (vs_o)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   typedef struct {
      logic [9:0]  h;
      logic [9:0]  v;
      logic        hs;
      logic [10:0] vaddr;
      logic        chk_cg;
      logic [10:0] cg;
      logic [2:0]  rgb;
      logic        de;
   } vec_t;

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [9:0] h, input logic [9:0] v,
                        input logic hs, input logic vs);
      h_cnt = h;
      v_cnt = v;
      hs_i  = hs;
      vs_i  = vs;
   endtask

   task automatic filler;
      drive(10'd700, 10'd500, 1'b1, 1'b1);
   endtask

   task automatic vs_pulse;
      drive(10'd700, 10'd500, 1'b1, 1'b0);
      tick;
      filler;
      tick;
   endtask

   task automatic run_vec(input vec_t t, input string tag);
      drive(t.h, t.v, t.hs, 1'b1);
      tick;
      chk({tag, " vaddr"}, 16'(vram_addr), 16'(t.vaddr));
      filler;
      tick;
      if (t.chk_cg) chk({tag, " cg"}, 16'(cg_addr), 16'(t.cg));
      tick;
      tick;
      chk({tag, " rgb"}, 16'({r_o, g_o, b_o}), 16'(t.rgb));
      chk({tag, " de"}, 16'(de_o), 16'(t.de));
      chk({tag, " hs"}, 16'(hs_o), 16'(t.hs));
      chk({tag, " vs"}, 16'(vs_o), 16'd1);
   endtask

   function automatic vec_t mk(input logic [9:0] h, input logic [9:0] v,
                               input logic hs, input logic [10:0] va,
                               input logic cc, input logic [10:0] cg,
                               input logic [2:0] rgb, input logic de);
      vec_t t;
      t.h = h; t.v = v; t.hs = hs; t.vaddr = va;
      t.chk_cg = cc; t.cg = cg; t.rgb = rgb; t.de = de;
      return t;
   endfunction

   vec_t tbl [18];

   initial begin
      for (int i = 0; i < 2048; i++) begin
         vram[i] = 8'h00;
         font[i] = 8'h00;
      end
      vram[0]    = 8'h41;
      vram[81]   = 8'h43;
      vram[1999] = 8'h42;
      font[11'h208] = 8'h80;
      font[11'h209] = 8'h01;
      font[11'h217] = 8'h01;
      font[11'h21B] = 8'hA5;

      tbl[0]  = mk(10'd0,   10'd40,  1, 11'd0,    1, 11'h208, 3'b111, 1);
      tbl[1]  = mk(10'd0,   10'd41,  1, 11'd0,    1, 11'h208, 3'b111, 1);
      tbl[2]  = mk(10'd1,   10'd40,  1, 11'd0,    1, 11'h208, 3'b000, 1);
      tbl[3]  = mk(10'd639, 10'd439, 1, 11'd1999, 1, 11'h217, 3'b111, 1);
      tbl[4]  = mk(10'd632, 10'd439, 1, 11'd1999, 1, 11'h217, 3'b000, 1);
      tbl[5]  = mk(10'd640, 10'd40,  1, 11'd0,    0, 11'h000, 3'b000, 0);
      tbl[6]  = mk(10'd0,   10'd39,  1, 11'd0,    0, 11'h000, 3'b000, 0);
      tbl[7]  = mk(10'd0,   10'd440, 1, 11'd0,    0, 11'h000, 3'b000, 0);
      tbl[8]  = mk(10'd8,   10'd62,  1, 11'd81,   1, 11'h21B, 3'b111, 1);
      tbl[9]  = mk(10'd9,   10'd62,  1, 11'd81,   1, 11'h21B, 3'b000, 1);
      tbl[10] = mk(10'd15,  10'd62,  1, 11'd81,   1, 11'h21B, 3'b111, 1);
      tbl[11] = mk(10'd14,  10'd62,  1, 11'd81,   1, 11'h21B, 3'b000, 1);
      tbl[12] = mk(10'd0,   10'd42,  1, 11'd0,    1, 11'h209, 3'b000, 1);
      tbl[13] = mk(10'd7,   10'd43,  1, 11'd0,    1, 11'h209, 3'b111, 1);
      tbl[14] = mk(10'd799, 10'd524, 0, 11'd0,    0, 11'h000, 3'b000, 0);
      tbl[15] = mk(10'd8,   10'd40,  1, 11'd1,    1, 11'h000, 3'b000, 1);
      tbl[16] = mk(10'd632, 10'd40,  1, 11'd79,   1, 11'h000, 3'b000, 1);
      tbl[17] = mk(10'd0,   10'd424, 1, 11'd1920, 1, 11'h000, 3'b000, 1);

      rst    = 1'b1;
      fg_i   = 3'b111;
      cur_x  = 7'd0;
      cur_y  = 5'd0;
      cur_on = 1'b0;
      filler;
      tick;
      tick;
      tick;
      chk("rst rgb", 16'({r_o, g_o, b_o}), 16'd0);
      chk("rst de", 16'(de_o), 16'd0);
      chk("rst hs", 16'(hs_o), 16'd1);
      chk("rst vs", 16'(vs_o), 16'd1);
      chk("rst vaddr", 16'(vram_addr), 16'd0);
      chk("rst cg", 16'(cg_addr), 16'd0);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // foreground change mid-frame, then a VS fall
      fg_i = 3'b100;
      run_vec(mk(10'd0, 10'd40, 1, 11'd0, 1, 11'h208, 3'b111, 1), "fg mid");
      drive(10'd700, 10'd500, 1'b1, 1'b0);
      tick;
      filler;
      tick;
      tick;
      tick;
      chk("vs delay", 16'(vs_o), 16'd0);
      run_vec(mk(10'd0, 10'd40, 1, 11'd0, 1, 11'h208, 3'b100, 1), "fg new");
      run_vec(mk(10'd1, 10'd40, 1, 11'd0, 1, 11'h208, 3'b000, 1), "fg bg");
      fg_i = 3'b010;
      run_vec(mk(10'd0, 10'd40, 1, 11'd0, 1, 11'h208, 3'b100, 1), "fg hold");

      // reset in the middle of an active stream
      drive(10'd0, 10'd40, 1'b0, 1'b1);
      tick;
      tick;
      tick;
      tick;
      chk("pre-rst de", 16'(de_o), 16'd1);
      chk("pre-rst hs", 16'(hs_o), 16'd0);
      chk("pre-rst rgb", 16'({r_o, g_o, b_o}), 16'b100);
      rst = 1'b1;
      tick;
      chk("mid-rst rgb", 16'({r_o, g_o, b_o}), 16'd0);
      chk("mid-rst de", 16'(de_o), 16'd0);
      chk("mid-rst hs", 16'(hs_o), 16'd1);
      chk("mid-rst vs", 16'(vs_o), 16'd1);
      chk("mid-rst vaddr", 16'(vram_addr), 16'd0);
      chk("mid-rst cg", 16'(cg_addr), 16'd0);
      tick;
      tick;
      rst = 1'b0;
      drive(10'd0, 10'd40, 1'b1, 1'b1);
      tick;
      filler;
      tick;
      tick;
      chk("post-rst de3", 16'(de_o), 16'd0);
      tick;
      chk("post-rst de4", 16'(de_o), 16'd1);
      chk("post-rst rgb4", 16'({r_o, g_o, b_o}), 16'b111);

      // blinking cursor on the last cell of a blank screen
      vram[1999] = 8'h00;
      fg_i = 3'b111;
      rst  = 1'b1;
      tick;
      tick;
      rst    = 1'b0;
      cur_x  = 7'd79;
      cur_y  = 5'd24;
      cur_on = 1'b1;
      for (int f = 0; f < 32; f++) begin
         logic [2:0] e;
         e = (CUR_BUILT && f < 16) ? 3'b111 : 3'b000;
         run_vec(mk(10'd632, 10'd424, 1, 11'd1999, 1, 11'h000, e, 1),
                 $sformatf("cur f%0d tl", f));
         run_vec(mk(10'd639, 10'd439, 1, 11'd1999, 1, 11'h007, e, 1),
                 $sformatf("cur f%0d br", f));
         run_vec(mk(10'd624, 10'd424, 1, 11'd1998, 1, 11'h000, 3'b000, 1),
                 $sformatf("cur f%0d nb", f));
         vs_pulse;
      end

      // out-of-range cursor column never matches
      cur_x = 7'd80;
      for (int f = 0; f < 32; f++) begin
         run_vec(mk(10'd632, 10'd424, 1, 11'd1999, 1, 11'h000, 3'b000, 1),
                 $sformatf("x80 f%0d a", f));
         run_vec(mk(10'd0, 10'd424, 1, 11'd1920, 1, 11'h000, 3'b000, 1),
                 $sformatf("x80 f%0d b", f));
         vs_pulse;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/crt_text_gen.md
CRT_TEXT_GEN -- requirements
Module: crt_text_gen

Interface
REQ-001 SHALL: parameter V_TOP, default 40, first V_CNT line of the text area.
REQ-002 SHALL: parameter FG_DEFAULT, default 3'b111, foreground RGB used at reset.
REQ-003 SHALL: I_CLK  in  1  25MHz pixel clock, shared with the H/V counter generator.
REQ-004 SHALL: I_RST  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL: I_H_CNT  in  10  horizontal count, 0..799, from the H/V generator.
REQ-006 SHALL: I_V_CNT  in  10  vertical count, 0..524, from the H/V generator.
REQ-007 SHALL: I_HS / I_VS  in  1 each  active-low syncs aligned with I_H_CNT/I_V_CNT.
REQ-008 SHALL: I_FG  in  3  foreground {R,G,B}, sampled once per frame at VS falling edge.
REQ-009 SHALL: O_VRAM_ADDR  out  11  text VRAM read address; I_VRAM_DATA  in  8  character code, 1-cycle synchronous read.
REQ-010 SHALL: O_CG_ADDR  out  11  font ROM address {code,line[2:0]}; I_CG_DATA  in  8  font row, 1-cycle synchronous read, MSB leftmost.
REQ-011 SHALL: I_CUR_X  in  7, I_CUR_Y  in  5, I_CUR_ON  in  1  cursor column, row, enable.
REQ-012 SHALL: O_R, O_G, O_B  out  1 each pixel colour; O_DE  out  1 display enable; O_HS, O_VS  out  1 each delayed syncs.

Function
REQ-013 SHALL: text area = H_CNT 0..639, V_CNT V_TOP..V_TOP+399; 80 cols x 25 rows, cell 8 px wide, 16 lines tall (8 font lines, each shown twice).
REQ-014 SHALL: stage 1 register O_VRAM_ADDR = row*80 + col; col = H_CNT[9:3]; row = (V_CNT-V_TOP)>>4; range 0..1999; 0 outside text area.
REQ-015 SHALL: stage 2 register O_CG_ADDR = {I_VRAM_DATA, ((V_CNT-V_TOP)>>1)[2:0]} using counters delayed one stage.
REQ-016 SHALL: stage 3 select pixel = I_CG_DATA[7 - hbit], hbit = H_CNT[2:0] delayed two stages.
REQ-017 SHALL: stage 4 register O_R/O_G/O_B = pixel ? fg : 3'b000; total latency counter->pixel = 4 clocks.
REQ-018 SHALL: O_HS, O_VS, O_DE be delayed exactly 4 clocks so they align with the pixel they accompany.
REQ-019 SHALL: outside text area O_DE=0 and RGB=000 regardless of memory data.
REQ-020 SHALL: fg register update only on I_VS 1->0 transition; mid-frame I_FG changes take effect next frame.
REQ-021 SHALL: H wrap 799->0 and V wrap 524->0 need no special handling; each column/row computed afresh every clock.
REQ-022 SHALL: cursor column/row values out of range (X>=80 or Y>=25) never match any cell.

Reset
REQ-023 SHALL: while I_RST=1 at a clock edge: RGB=000, O_DE=0, O_HS=1, O_VS=1, O_VRAM_ADDR=0, O_CG_ADDR=0, fg=FG_DEFAULT, blink counter=0, blink phase=visible, all pipeline stages cleared.
REQ-024 SHALL: reset asserted mid-frame take effect on the next edge; after release, first valid pixel appears 4 clocks after first in-area counter value.

Configuration
REQ-025 SHALL: macro CRT_TEXT_CURSOR_EN defined: cell matching (I_CUR_X, I_CUR_Y) with I_CUR_ON=1 and blink phase visible outputs inverted pixel (fg where font 0, black where 1).
REQ-026 SHALL: with CRT_TEXT_CURSOR_EN, 5-bit blink counter increments on each I_VS falling edge; phase = counter[4] inverted (16 frames visible, 16 hidden).
REQ-027 SHALL: without CRT_TEXT_CURSOR_EN, cursor ports remain but are ignored; blink counter not built; output is pure font data.

Structure
REQ-028 SHALL: package pc8k_video_pkg hold H_ACTIVE=640, TXT_COLS=80, TXT_ROWS=25, CELL_W=8, CELL_H=16, PIPE_LAT=4, BLINK_BITS=5.
REQ-029 SHALL: sub-module crt_delay_line (parameter width and depth, sync reset to parameterised value) carries HS/VS/DE and H/V LSBs through the pipeline.

Verification
REQ-030 SHALL: reset held 3 clocks mid-frame -> O_HS=1, O_VS=1, O_DE=0, RGB=000 on the next edge.
REQ-031 SHALL: H=0,V=40 -> O_VRAM_ADDR=0 one clock later; H=639,V=439 -> 1999; H=640 -> O_DE=0 four clocks later.
REQ-032 SHALL: VRAM code 0x41, font row line 0 = 0x80, fg=111 -> pixel at H=0,V=40 and V=41 white at output clock +4, H=1 black.
REQ-033 SHALL: I_FG changed to 100 at V=200 -> rest of frame unchanged; after next VS fall foreground pixels red only.
REQ-034 SHALL (CRT_TEXT_CURSOR_EN): cursor (79,24), I_CUR_ON=1, blank code 0x00 font -> cell H 632..639, V 424..439 white frames 0-15, black frames 16-31.
REQ-035 SHALL: cursor X=80 -> no inverted cell anywhere over 32 frames.
